// File: rtl/fifo_pkg.sv
// Shared defaults and types for the FIFO write scheduler.
// Also provides the index-width helper used by every file of the block.
package fifo_pkg;

   localparam int unsigned DefNReq     = 4;
   localparam int unsigned DefDw       = 8;
   localparam int unsigned DefMaxBurst = 4;
   localparam int unsigned FifoDepth   = 16;

   typedef enum logic {StIdle, StBurst} sched_state_e;

   // Port-index width; never narrower than one bit so a single-port build still elaborates.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_wr_sched_if.sv
// Producer-side handshake plus FIFO write port seen by the scheduler.
// The master modport is the scheduler side and the slave modport is the environment side.
interface fifo_wr_sched_if #(
   parameter int unsigned N_REQ = fifo_pkg::DefNReq,
   parameter int unsigned DW    = fifo_pkg::DefDw
);

   localparam int unsigned IW = fifo_pkg::idx_width(N_REQ);

   logic [N_REQ-1:0]    req;
   logic [N_REQ*DW-1:0] req_data;
   logic [N_REQ-1:0]    req_last;
   logic [N_REQ-1:0]    gnt;
   logic                fifo_full;
   logic                fifo_wr_en;
   logic [DW-1:0]       fifo_data;
   logic                busy;
   logic [IW-1:0]       owner;

   modport master (
      input  req, req_data, req_last, fifo_full,
      output gnt, fifo_wr_en, fifo_data, busy, owner
   );

   modport slave (
      output req, req_data, req_last, fifo_full,
      input  gnt, fifo_wr_en, fifo_data, busy, owner
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requester at or after rr_ptr_i, wrapping around.
module rr_arbiter
   import fifo_pkg::*;
#(
   parameter int unsigned N_REQ = DefNReq,
   parameter int unsigned IW    = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IW-1:0]    rr_ptr_i,
   output logic             valid_o,
   output logic [IW-1:0]    index_o
);

   int unsigned   cand;
   logic [IW-1:0] cand_idx;

   always_comb begin
      valid_o  = 1'b0;
      index_o  = '0;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand     = (32'(rr_ptr_i) + k) % N_REQ;
         cand_idx = IW'(cand);
         if (!valid_o && req_i[cand_idx]) begin
            valid_o = 1'b1;
            index_o = cand_idx;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_sched.sv
// Round-robin burst scheduler that lets N_REQ producers share one FIFO write port.
// N_REQ and DW must match the parameters of the connected interface instance.
module fifo_wr_sched
   import fifo_pkg::*;
#(
   parameter int unsigned N_REQ     = DefNReq,
   parameter int unsigned DW        = DefDw,
   parameter int unsigned MAX_BURST = DefMaxBurst
) (
   input logic             clk,
   input logic             reset,
   fifo_wr_sched_if.master bus
);

   localparam int unsigned IW = idx_width(N_REQ);
   localparam int unsigned CW = $clog2(MAX_BURST + 1);

   sched_state_e  state_q, state_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic [CW-1:0] count_q, count_d, count_inc;
   logic          arb_valid;
   logic [IW-1:0] arb_index;
   logic          owner_req, owner_last, accept, burst_done;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_arb (
      .req_i    (bus.req),
      .rr_ptr_i (rr_ptr_q),
      .valid_o  (arb_valid),
      .index_o  (arb_index)
   );

   always_comb begin
      owner_req     = 1'b0;
      owner_last    = 1'b0;
      bus.fifo_data = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (owner_q == IW'(i)) begin
            owner_req     = bus.req[i];
            owner_last    = bus.req_last[i];
            bus.fifo_data = bus.req_data[i*DW +: DW];
         end
      end
   end

   // Reset gates the grant so nothing is written in a reset cycle, even mid-burst.
   assign accept = (state_q == StBurst) && !reset && owner_req && !bus.fifo_full;

   always_comb begin
      bus.gnt = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         bus.gnt[i] = accept && (owner_q == IW'(i));
      end
   end

   assign bus.fifo_wr_en = |bus.gnt;
   assign bus.busy       = (state_q == StBurst);
   assign bus.owner      = owner_q;
   assign count_inc      = count_q + CW'(1);

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      count_d    = count_q;
      burst_done = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (arb_valid) begin
               owner_d = arb_index;
               count_d = '0;
               state_d = StBurst;
            end
         end
         StBurst: begin
            if (!owner_req) begin
               burst_done = 1'b1;
            end else if (accept) begin
               count_d    = count_inc;
               burst_done = owner_last || (count_inc == CW'(MAX_BURST));
            end
            if (burst_done) begin
               state_d  = StIdle;
               rr_ptr_d = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_sched.sv
// Bench for fifo_wr_sched: directed scenarios and random traffic against a cycle reference model,
// plus a MAX_BURST=16 instance feeding a 16-deep FIFO model for the fill test.
module tb_fifo_wr_sched;
   import fifo_pkg::*;

   localparam int unsigned NR = DefNReq;
   localparam int unsigned W  = DefDw;
   localparam int          MB = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fifo_wr_sched_if #(.N_REQ(NR), .DW(W)) bus_a ();
   fifo_wr_sched_if #(.N_REQ(NR), .DW(W)) bus_b ();

   fifo_wr_sched #(.N_REQ(NR), .DW(W), .MAX_BURST(MB)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   fifo_wr_sched #(.N_REQ(NR), .DW(W), .MAX_BURST(16)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   int n_pass = 0, n_checks = 0, n_fail = 0;

   // Producer sources for instance A: words left, current word, whether the final word is last.
   int         s_left[NR];
   logic [7:0] s_data[NR];
   bit         s_last[NR];
   logic       a_full;

   // Reference model of the scheduling rules.
   bit m_busy;
   int m_owner, m_cnt, m_ptr;

   logic [7:0] wr_log[$];
   int         own_log[$];

   // FIFO model for instance B.
   logic [7:0] fq[$];
   logic [7:0] rx[$];
   logic       rd_en;
   int         ovf;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle_a(input string tag);
      logic [NR-1:0] r;
      logic [NR-1:0] eg;
      bit            lastbit, acc, done, found;
      for (int p = 0; p < NR; p++) begin
         r[p]                       = (s_left[p] > 0);
         bus_a.req[p]               = r[p];
         bus_a.req_data[p*W +: W]   = s_data[p];
         bus_a.req_last[p]          = s_last[p] && (s_left[p] == 1);
      end
      bus_a.fifo_full = a_full;
      @(negedge clk);
      eg = '0;
      if (!reset && m_busy && r[m_owner] && !a_full) eg[m_owner] = 1'b1;
      acc = |eg;
      check({tag, "_gnt"}, 32'(bus_a.gnt), 32'(eg));
      check({tag, "_wr"}, 32'(bus_a.fifo_wr_en), 32'(acc));
      check({tag, "_busy"}, 32'(bus_a.busy), 32'(m_busy));
      check({tag, "_owner"}, 32'(bus_a.owner), 32'(m_owner));
      if (acc) begin
         check({tag, "_data"}, 32'(bus_a.fifo_data), 32'(s_data[m_owner]));
         wr_log.push_back(bus_a.fifo_data);
         own_log.push_back(int'(bus_a.owner));
      end
      if (reset) begin
         m_busy = 0; m_ptr = 0; m_owner = 0; m_cnt = 0;
      end else if (!m_busy) begin
         found = 0;
         for (int k = 0; k < NR; k++) begin
            if (!found && r[(m_ptr + k) % NR]) begin
               found = 1;
               m_owner = (m_ptr + k) % NR;
            end
         end
         if (found) begin
            m_busy = 1;
            m_cnt  = 0;
         end
      end else begin
         lastbit = s_last[m_owner] && (s_left[m_owner] == 1);
         done = 0;
         if (!r[m_owner]) done = 1;
         else if (acc) begin
            m_cnt++;
            if (lastbit || m_cnt == MB) done = 1;
         end
         if (done) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % NR;
         end
      end
      if (acc) begin
         s_left[m_owner]--;
         s_data[m_owner]++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_until_wr(input int n, input int budget, input string tag);
      int c = 0;
      while (wr_log.size() < n && c < budget) begin
         cycle_a(tag);
         c++;
      end
      check({tag, "_reached"}, 32'(wr_log.size() >= n), 1);
   endtask

   task automatic clear_src();
      for (int p = 0; p < NR; p++) begin
         s_left[p] = 0; s_data[p] = '0; s_last[p] = 0;
      end
   endtask

   always @(posedge clk) begin
      if (reset) begin
         fq.delete();
         bus_b.fifo_full <= 1'b0;
      end else begin
         if (bus_b.fifo_wr_en) begin
            if (fq.size() >= FifoDepth) ovf <= ovf + 1;
            else fq.push_back(bus_b.fifo_data);
         end
         if (rd_en && fq.size() > 0) rx.push_back(fq.pop_front());
         bus_b.fifo_full <= (fq.size() >= FifoDepth);
      end
   end

   initial begin
      int exp_own[5] = '{0, 1, 2, 3, 0};
      int exp_rel[4] = '{1, 1, 3, 0};
      int b_left, nwr_before, after_full, cyc;
      logic [7:0] b_data;
      bit seen_full, pop_b;

      ovf = 0;
      rd_en = 1'b0;
      a_full = 1'b0;
      clear_src();
      bus_b.req = '0; bus_b.req_data = '0; bus_b.req_last = '0;
      m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      cycle_a("rst");
      reset = 1'b0;

      // Single port, four words, last on the fourth.
      wr_log.delete(); own_log.delete();
      s_left[0] = 4; s_data[0] = 8'hA0; s_last[0] = 1;
      repeat (8) cycle_a("single");
      check("single_nwr", wr_log.size(), 4);
      for (int i = 0; i < 4; i++) check("single_word", wr_log[i], 32'hA0 + i);

      // Contention after reset: bursts of four rotate 0,1,2,3,0.
      reset = 1'b1;
      cycle_a("rst2");
      reset = 1'b0;
      wr_log.delete(); own_log.delete();
      for (int p = 0; p < NR; p++) begin
         s_left[p] = 100; s_data[p] = 8'(p << 6); s_last[p] = 0;
      end
      repeat (25) cycle_a("cont");
      clear_src();
      repeat (2) cycle_a("cont_tail");
      check("cont_nwr", own_log.size(), 20);
      for (int i = 0; i < 20 && i < own_log.size(); i++)
         check("cont_owner", own_log[i], exp_own[i/4]);

      // Full stall mid-burst on port 2.
      wr_log.delete(); own_log.delete();
      s_left[2] = 4; s_data[2] = 8'hC0; s_last[2] = 1;
      run_until_wr(2, 10, "stall_pre");
      a_full = 1'b1;
      repeat (3) cycle_a("stall");
      a_full = 1'b0;
      repeat (6) cycle_a("stall_post");
      check("stall_nwr", wr_log.size(), 4);
      for (int i = 0; i < 4 && i < wr_log.size(); i++) begin
         check("stall_word", wr_log[i], 32'hC0 + i);
         check("stall_owner", own_log[i], 2);
      end

      // Release: port 1 supplies two words then drops; search resumes at port 2.
      clear_src();
      wr_log.delete(); own_log.delete();
      s_left[1] = 2; s_data[1] = 8'hD0;
      cycle_a("rel_arb");
      s_left[0] = 1; s_data[0] = 8'h50; s_last[0] = 1;
      s_left[3] = 1; s_data[3] = 8'h53; s_last[3] = 1;
      repeat (10) cycle_a("rel");
      check("rel_nwr", own_log.size(), 4);
      for (int i = 0; i < 4 && i < own_log.size(); i++) check("rel_owner", own_log[i], exp_rel[i]);

      // Reset while port 2 holds the grant.
      clear_src();
      wr_log.delete(); own_log.delete();
      s_left[2] = 4; s_data[2] = 8'hE0; s_last[2] = 1;
      run_until_wr(1, 10, "mid_pre");
      s_left[0] = 2; s_data[0] = 8'h10; s_last[0] = 1;
      s_left[3] = 2; s_data[3] = 8'h30; s_last[3] = 1;
      reset = 1'b1;
      cycle_a("mid_rst");
      reset = 1'b0;
      wr_log.delete(); own_log.delete();
      repeat (14) cycle_a("mid_post");
      check("mid_first_owner", (own_log.size() > 0) ? own_log[0] : 99, 0);

      // Random traffic with occasional full, release and reset.
      clear_src();
      for (int n = 0; n < 400; n++) begin
         for (int p = 0; p < NR; p++) begin
            if (s_left[p] == 0 && $urandom_range(0, 3) == 0) begin
               s_left[p] = $urandom_range(1, 7);
               s_data[p] = 8'($urandom);
               s_last[p] = 1'($urandom_range(0, 1));
            end else if ($urandom_range(0, 15) == 0) begin
               s_left[p] = 0;
            end
         end
         a_full = ($urandom_range(0, 3) == 0);
         reset  = ($urandom_range(0, 63) == 0);
         cycle_a("rand");
      end
      reset = 1'b0;
      a_full = 1'b0;
      clear_src();

      // Fill test on the MAX_BURST=16 instance: port 0 streams 20 words into a 16-deep FIFO.
      b_left = 20; b_data = 8'h00;
      nwr_before = 0; after_full = 0; seen_full = 0; cyc = 0;
      while (rx.size() < 20 && cyc < 300) begin
         bus_b.req      = {3'b000, (b_left > 0)};
         bus_b.req_data = {24'h0, b_data};
         bus_b.req_last = '0;
         @(negedge clk);
         if (bus_b.fifo_full) check("fill_no_wr_full", 32'(bus_b.fifo_wr_en), 0);
         if (!seen_full) begin
            if (bus_b.fifo_full) seen_full = 1;
            else if (bus_b.fifo_wr_en) nwr_before++;
         end else begin
            after_full++;
         end
         pop_b = bus_b.gnt[0];
         @(posedge clk);
         #1;
         if (pop_b) begin
            b_left--;
            b_data++;
         end
         if (after_full >= 5) rd_en = 1'b1;
         cyc++;
      end
      rd_en = 1'b0;
      check("fill_writes_before_full", nwr_before, 16);
      check("fill_rx_count", rx.size(), 20);
      check("fill_overflow", ovf, 0);
      for (int i = 0; i < 20 && i < rx.size(); i++) check("fill_data", rx[i], i);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
